freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 151 +++++++++++++++
 tb/tb_freq_meter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Counts rising edges of an asynchronous input over a programmable window of
//   clk cycles. A window is started by a one-cycle start pulse (or auto-repeats
//   when continuous is set). At the end of each window the edge count is
//   published on count with a one-cycle valid pulse. ovf flags a saturated
//   result. stop aborts a window without publishing anything.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   sig_in      asynchronous signal being measured
//   gate_len    window length in clk cycles (0 is treated as 1)
//   start       one-cycle request to begin a window (ignored while busy)
//   continuous  when 1, a new window begins right after each DONE cycle
//   stop        aborts any window in progress, returns to IDLE
//   count       last completed edge count
//   valid       one-cycle pulse when count/ovf update
//   ovf         last result saturated at 2^CNT_W-1
//   busy        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [GATE_W-1:0]  r_gate_rem;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_ovf_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_valid;

  logic               w_rise;
  logic [GATE_W-1:0]  w_gate_load;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_acc_nxt;

  // r_s1/r_s2 form the metastability synchronizer; r_s3 is only a delayed
  // copy of the clean signal used for edge detection.
  assign w_rise      = r_s2 & ~r_s3;

  // A zero-length window would never reach gate_rem==1, so it runs as one cycle.
  assign w_gate_load = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cnt_nxt = r_edge_cnt;
    w_acc_nxt = r_ovf_acc;
    if (w_rise) begin
      if (r_edge_cnt == '1) begin
        w_acc_nxt = 1'b1;          // saturate instead of wrapping
      end else begin
        w_cnt_nxt = r_edge_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_gate_rem <= '0;
      r_edge_cnt <= '0;
      r_ovf_acc  <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_s1    <= sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;

      if (stop) begin
        // Abort: published result is left untouched.
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_gate_rem <= w_gate_load;
              r_edge_cnt <= '0;
              r_ovf_acc  <= 1'b0;
              r_state    <= GATE;
            end
          end

          GATE: begin
            r_gate_rem <= r_gate_rem - GATE_W'(1);
            r_edge_cnt <= w_cnt_nxt;
            r_ovf_acc  <= w_acc_nxt;
            if (r_gate_rem == GATE_W'(1)) begin
              // Publish including any rise on this final cycle.
              r_count <= w_cnt_nxt;
              r_ovf   <= w_acc_nxt;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          end

          DONE: begin
            if (continuous) begin
              r_gate_rem <= w_gate_load;
              r_edge_cnt <= '0;
              r_ovf_acc  <= 1'b0;
              r_state    <= GATE;
            end else begin
              r_state <= IDLE;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign valid = r_valid;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//   Directed bench for freq_meter. Two instances share all inputs: one at the
//   default widths and one with CNT_W=4 to reach saturation quickly. sig_in is
//   generated as a square wave with a programmable half-period, advanced once
//   per clock inside tick(). Expected counts follow from the fact that a
//   steady square wave of period P yields exactly N/P rises in any N
//   consecutive window cycles.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [31:0] gate_len;
  logic        start;
  logic        continuous;
  logic        stop;

  logic [31:0] count;
  logic        valid;
  logic        ovf;
  logic        busy;

  logic [3:0]  count4;
  logic        valid4;
  logic        ovf4;
  logic        busy4;

  int n_vec = 0;
  int n_err = 0;
  int half  = 0;   // sig_in half-period in clk cycles, 0 = hold
  int ph    = 0;

  always #5 clk = ~clk;

  freq_meter dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .gate_len   (gate_len),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .count      (count),
    .valid      (valid),
    .ovf        (ovf),
    .busy       (busy)
  );

  freq_meter #(.CNT_W(4), .GATE_W(32)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .gate_len   (gate_len),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .count      (count4),
    .valid      (valid4),
    .ovf        (ovf4),
    .busy       (busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (half > 0) begin
      ph++;
      if (ph >= half) begin
        sig_in = ~sig_in;
        ph     = 0;
      end
    end
  endtask

  // Tick until valid is seen; n is the number of ticks taken (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 500);
  endtask

  task automatic run_wave(input int h);
    half   = h;
    ph     = 0;
    sig_in = 1'b0;
    repeat (2 * h + 4) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int nv;

    rst        = 1'b1;
    sig_in     = 1'b0;
    gate_len   = 32'd0;
    start      = 1'b0;
    continuous = 1'b0;
    stop       = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf",   ovf,   0);
    check("rst_busy",  busy,  0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_after_rst_busy", busy, 0);

    // 100-cycle window, sig_in period 10
    run_wave(5);
    gate_len = 32'd100;
    pulse_start();
    check("w100_busy", busy, 1);
    wait_valid(n);
    check("w100_len",   n,     100);
    check("w100_count", count, 10);
    check("w100_ovf",   ovf,   0);
    tick();
    check("w100_valid_1cyc", valid, 0);
    check("w100_idle",       busy,  0);
    check("w100_hold",       count, 10);

    // Saturation: 64 cycles, rise every 2 cycles = 32 rises
    run_wave(1);
    gate_len = 32'd64;
    pulse_start();
    wait_valid(n);
    check("sat_len",    n,      64);
    check("sat_count4", count4, 15);
    check("sat_ovf4",   ovf4,   1);
    check("sat_count",  count,  32);
    check("sat_ovf",    ovf,    0);
    tick();

    // Continuous mode: 20-cycle windows, period 4
    run_wave(2);
    gate_len   = 32'd20;
    continuous = 1'b1;
    pulse_start();
    wait_valid(n);
    check("cont_first_len",   n,     20);
    check("cont_first_count", count, 5);
    wait_valid(n);
    check("cont_period",      n,     21);
    check("cont_count2",      count, 5);
    check("cont_ovf4",        ovf4,  0);
    tick();
    continuous = 1'b0;
    check("cont_regate_busy", busy, 1);
    wait_valid(n);
    check("cont_last_len",   n,     20);
    check("cont_last_count", count, 5);
    tick();
    check("cont_end_busy", busy, 0);
    nv = 0;
    repeat (30) begin
      tick();
      if (valid) nv++;
    end
    check("cont_no_more_valid", nv, 0);

    // gate_len = 0: steady input gives 0, aligned rise gives 1
    half   = 0;
    sig_in = 1'b0;
    repeat (4) tick();
    gate_len = 32'd0;
    pulse_start();
    wait_valid(n);
    check("g0_len",   n,     1);
    check("g0_count", count, 0);
    tick();
    sig_in = 1'b1;
    tick();
    pulse_start();
    check("g0r_busy", busy, 1);
    tick();
    check("g0r_valid", valid, 1);
    check("g0r_count", count, 1);
    tick();
    sig_in = 1'b0;
    repeat (4) tick();

    // start and gate_len change mid-window have no effect
    run_wave(3);
    gate_len = 32'd30;
    pulse_start();
    repeat (9) tick();
    gate_len = 32'd5;
    pulse_start();
    wait_valid(n);
    check("restart_ignored_len", n,     20);
    check("restart_count",       count, 5);
    tick();

    // stop mid-GATE
    gate_len = 32'd30;
    pulse_start();
    repeat (10) tick();
    check("stop_pre_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy",   busy,   0);
    check("stop_valid",  valid,  0);
    check("stop_count",  count,  5);
    check("stop_count4", count4, 5);
    nv = 0;
    repeat (40) begin
      tick();
      if (valid) nv++;
    end
    check("stop_no_valid", nv, 0);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check("stop_beats_start", busy, 0);

    // rst on the last GATE cycle
    run_wave(1);
    gate_len = 32'd10;
    pulse_start();
    repeat (9) tick();
    check("rst_last_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("rstlast_valid",  valid,  0);
    check("rstlast_count",  count,  0);
    check("rstlast_ovf",    ovf,    0);
    check("rstlast_busy",   busy,   0);
    check("rstlast_count4", count4, 0);
    rst = 1'b0;
    nv  = 0;
    repeat (20) begin
      tick();
      if (valid || busy) nv++;
    end
    check("rstlast_stay_idle", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
